// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-atomic arbiter feeding a single registered valid/ready stage.
// out_src tags every beat with the requester index so responses can be routed back.
module stream_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       in_valid,
  output logic [NUM_REQ-1:0]       in_ready,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]       in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [IDW-1:0]           out_src
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   lock_q, lock_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [IDW-1:0]   out_src_q, out_src_d;

  logic               stage_en;
  logic               grant_vld;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               sel_valid;
  logic               sel_last;
  logic [WIDTH-1:0]   sel_data;
  logic               accept;
  int unsigned        scan_pos;

  assign stage_en = ~out_valid_q | out_ready;

  // Scan from ptr upward with wrap; first valid requester wins unless a packet holds the lock.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_pos  = 0;
    if (state_q == ST_LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = lock_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_pos = 32'(ptr_q) + k;
        if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
        if (!grant_vld && in_valid[IDW'(scan_pos)]) begin
          grant_vld = 1'b1;
          grant_idx = IDW'(scan_pos);
        end
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        grant_oh[i] = grant_vld;
        sel_valid   = in_valid[i];
        sel_last    = in_last[i];
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = stage_en ? grant_oh : '0;
  assign accept   = grant_vld & sel_valid & stage_en;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_src_d   = grant_idx;
      if (sel_last) begin
        state_d = ST_IDLE;
        ptr_d   = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
      end else begin
        state_d = ST_LOCKED;
        lock_d  = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lock_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_stream_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [IDW-1:0] out_src;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds the packet lock, where the scan starts, what sits in the slice.
  int         m_ptr;
  bit         m_locked;
  int         m_lock;
  bit         m_ov;
  logic [W-1:0] m_od;
  bit         m_ol;
  int         m_os;
  int         acc_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_lock = 0;
    m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
  endtask

  function automatic int model_grant();
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic set_data_default();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
  endtask

  // Check combinational and registered outputs mid-cycle, then advance one edge.
  task automatic cycle();
    int g;
    bit se, acc;
    logic [N-1:0] exp_rdy;
    #1;
    g  = model_grant();
    se = !m_ov || out_ready;
    exp_rdy = '0;
    if (g >= 0 && se) exp_rdy[g] = 1'b1;
    acc = (g >= 0) && in_valid[g] && se;
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      check_eq("out_data", 64'(out_data), 64'(m_od));
      check_eq("out_last", 64'(out_last), 64'(m_ol));
      check_eq("out_src", 64'(out_src), 64'(m_os));
    end
    @(posedge clk);
    if (acc) begin
      m_ov = 1; m_od = in_data[g*W +: W]; m_ol = in_last[g]; m_os = g;
      acc_log.push_back(g);
      if (in_last[g]) begin
        m_locked = 0;
        m_ptr = (g + 1) % N;
      end else begin
        m_locked = 1;
        m_lock = g;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l);
    in_valid = v;
    in_last  = l;
    cycle();
  endtask

  task automatic check_log(input string tag, input int exp[$]);
    check_eq({tag, "_count"}, 64'(acc_log.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < acc_log.size(); k++)
      check_eq($sformatf("%s_src%0d", tag, k), 64'(acc_log[k]), 64'(exp[k]));
    acc_log.delete();
  endtask

  initial begin
    int c1;
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; out_ready = 1'b1;
    set_data_default();
    model_reset();

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_src", 64'(out_src), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    repeat (3) drive(4'b0000, 4'b0000);

    // Round-robin fairness with single-beat packets
    acc_log.delete();
    repeat (8) drive(4'b1111, 4'b1111);
    check_log("fair", '{0, 1, 2, 3, 0, 1, 2, 3});
    drive(4'b0000, 4'b0000);

    // Packet lock: req1 three beats while req0/req2 compete
    drive(4'b0001, 4'b0001);
    c1 = 0;
    for (int k = 0; k < 4; k++) begin
      drive(4'b0111, (c1 == 2) ? 4'b0111 : 4'b0101);
      c1 = 0;
      foreach (acc_log[j]) if (acc_log[j] == 1) c1++;
    end
    check_log("lock", '{0, 1, 1, 1, 2});
    drive(4'b0000, 4'b0000);

    // Bubble inside a lock: req0 must wait for req3's last beat
    drive(4'b1001, 4'b0001);
    drive(4'b0001, 4'b0001);
    drive(4'b0001, 4'b0001);
    drive(4'b1001, 4'b1001);
    drive(4'b0001, 4'b0001);
    check_log("bubble", '{3, 3, 0});
    drive(4'b0000, 4'b0000);

    // Backpressure: slice full, downstream stalled, then drain+load together
    drive(4'b0010, 4'b0010);
    out_ready = 1'b0;
    repeat (5) drive(4'b0110, 4'b0110);
    out_ready = 1'b1;
    drive(4'b0110, 4'b0110);
    check_log("bp", '{1, 2});
    check_eq("bp_no_bubble", 64'(out_valid), 64'd1);
    drive(4'b0000, 4'b0000);

    // Reset in the middle of a req0 packet
    drive(4'b0001, 4'b0000);
    drive(4'b0001, 4'b0000);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    model_reset();
    acc_log.delete();
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b0010, 4'b0010);
    check_log("midrst", '{1});

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      drive(N'($urandom), N'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
